idelay_eye_scanner: RTL and testbench

IDELAY_EYE_SCANNER -- requirements
Module: idelay_eye_scanner

---
 rtl/idelay_scan_pkg.sv | 30 +++
 rtl/scan_err_accum.sv | 44 ++++
 rtl/idelay_eye_scanner.sv | 195 +++++++++++++++++++
 tb/tb_idelay_eye_scanner.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/idelay_scan_pkg.sv
// Shared types and constants for the IDELAY eye scanner: scan FSM states,
// tap/counter widths, per-point log depth and the 8-bit popcount helper.
package idelay_scan_pkg;

   localparam int TAP_W     = 9;
   localparam int CNT_W     = 16;
   localparam int LOG_DEPTH = 64;
   localparam int LOG_AW    = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_DWELL,
      ST_EVAL,
      ST_CENTER,
      ST_APPLY,
      ST_DONE
   } scan_state_e;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/scan_err_accum.sv
// Per-tap bit-error accumulator: popcount of P against inverted N, 16-bit
// saturating sum, and a dwell counter that advances only on valid words.
module scan_err_accum
   import idelay_scan_pkg::*;
(
   input  logic             clk160,
   input  logic             rstb,
   input  logic             clr,
   input  logic             en,
   input  logic             data_valid,
   input  logic [7:0]       data_p,
   input  logic [7:0]       data_n,
   input  logic [CNT_W-1:0] dwell_cycles,
   output logic [CNT_W-1:0] err_acc,
   output logic             dwell_done
);

   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] dwell_target;
   logic [3:0]       word_err;
   logic [CNT_W:0]   acc_sum;

   // N carries the inverted reference, so a clean bit has data_p == ~data_n.
   always_comb begin
      word_err     = popcount8(data_p ^ ~data_n);
      dwell_target = (dwell_cycles == '0) ? CNT_W'(1) : dwell_cycles;
      acc_sum      = {1'b0, err_acc} + {{(CNT_W-3){1'b0}}, word_err};
      dwell_done   = en && data_valid && (word_cnt == dwell_target - CNT_W'(1));
   end

   always_ff @(posedge clk160 or negedge rstb) begin
      if (!rstb) begin
         err_acc  <= '0;
         word_cnt <= '0;
      end else if (clr) begin
         err_acc  <= '0;
         word_cnt <= '0;
      end else if (en && data_valid) begin
         err_acc  <= acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
         word_cnt <= word_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/idelay_eye_scanner.sv
// Sweeps the IDELAY tap, counts bit errors per tap and centres on the widest
// passing run. Optional per-point error log enabled by EYE_SCAN_LOG_EN.
module idelay_eye_scanner
   import idelay_scan_pkg::*;
#(
   parameter int TAP_STEP      = 8,
   parameter int TAP_MAX       = 511,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic             clk160,
   input  logic             rstb,
   input  logic             scan_start,
   input  logic             scan_abort,
   input  logic [CNT_W-1:0] dwell_cycles,
   input  logic [CNT_W-1:0] err_thresh,
   input  logic [7:0]       data_p,
   input  logic [7:0]       data_n,
   input  logic             data_valid,
   output logic [TAP_W-1:0] delay_set,
   output logic             delay_wr,
   output logic             busy,
   output logic             done,
   output logic             scan_fail,
   output logic [TAP_W-1:0] eye_start,
   output logic [TAP_W-1:0] eye_width,
   output logic [TAP_W-1:0] eye_center,
   input  logic [LOG_AW-1:0] log_addr,
   output logic [CNT_W-1:0] log_data
);

   localparam logic [TAP_W:0]   STEP_X      = (TAP_W+1)'(TAP_STEP);
   localparam logic [TAP_W:0]   MAX_X       = (TAP_W+1)'(TAP_MAX);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   scan_state_e state_q, state_d;

   logic [TAP_W-1:0] tap_q, delay_set_q;
   logic [TAP_W-1:0] run_first_q, run_last_q, best_first_q, best_last_q;
   logic [TAP_W-1:0] eye_start_q, eye_width_q, eye_center_q;
   logic             run_active_q, best_valid_q, scan_fail_q;
   logic [CNT_W-1:0] settle_cnt_q, err_acc;
   logic             dwell_done, acc_clr, acc_en;

   logic [TAP_W:0]   tap_next, best_width;
   logic             last_point, start_scan, tap_pass, close_run, take_best;
   logic [TAP_W-1:0] cand_first, close_first, close_last;

   // data_valid qualifies data_p/data_n for one word per cycle; there is no
   // backpressure, a word not taken while valid is simply not counted.
   scan_err_accum u_accum (
      .clk160       (clk160),
      .rstb         (rstb),
      .clr          (acc_clr),
      .en           (acc_en),
      .data_valid   (data_valid),
      .data_p       (data_p),
      .data_n       (data_n),
      .dwell_cycles (dwell_cycles),
      .err_acc      (err_acc),
      .dwell_done   (dwell_done)
   );

   always_comb begin
      start_scan  = (state_q == ST_IDLE) && scan_start && !scan_abort;
      tap_next    = {1'b0, tap_q} + STEP_X;
      last_point  = tap_next > MAX_X;
      acc_clr     = (state_q == ST_SETTLE) && (settle_cnt_q == SETTLE_LAST);
      acc_en      = (state_q == ST_DWELL);
      tap_pass    = err_acc <= err_thresh;
      cand_first  = run_active_q ? run_first_q : tap_q;
      // A passing last point closes the run that includes it.
      close_run   = (run_active_q && !tap_pass) || (tap_pass && last_point);
      close_first = tap_pass ? cand_first : run_first_q;
      close_last  = tap_pass ? tap_q : run_last_q;
      take_best   = close_run && (!best_valid_q ||
                    ((close_last - close_first) > (best_last_q - best_first_q)));
      best_width  = {1'b0, best_last_q} - {1'b0, best_first_q};
   end

   always_ff @(posedge clk160 or negedge rstb) begin
      if (!rstb) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_scan) state_d = ST_LOAD;
         ST_LOAD:   state_d = ST_SETTLE;
         ST_SETTLE: if (settle_cnt_q == SETTLE_LAST) state_d = ST_DWELL;
         ST_DWELL:  if (dwell_done) state_d = ST_EVAL;
         ST_EVAL:   state_d = last_point ? ST_CENTER : ST_LOAD;
         ST_CENTER: state_d = ST_APPLY;
         ST_APPLY:  state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (scan_abort && state_q != ST_IDLE) state_d = ST_IDLE;
   end

   always_comb begin
      busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
      done       = (state_q == ST_DONE) && !scan_abort;
      delay_wr   = ((state_q == ST_LOAD) || (state_q == ST_APPLY)) && !scan_abort;
      delay_set  = delay_set_q;
      if (state_q == ST_LOAD)  delay_set = tap_q;
      if (state_q == ST_APPLY) delay_set = eye_center_q;
      scan_fail  = scan_fail_q;
      eye_start  = eye_start_q;
      eye_width  = eye_width_q;
      eye_center = eye_center_q;
   end

   always_ff @(posedge clk160 or negedge rstb) begin
      if (!rstb) begin
         tap_q        <= '0;
         delay_set_q  <= '0;
         settle_cnt_q <= '0;
         run_active_q <= 1'b0;
         run_first_q  <= '0;
         run_last_q   <= '0;
         best_valid_q <= 1'b0;
         best_first_q <= '0;
         best_last_q  <= '0;
         scan_fail_q  <= 1'b0;
         eye_start_q  <= '0;
         eye_width_q  <= '0;
         eye_center_q <= '0;
      end else begin
         delay_set_q <= delay_set;
         if (state_q == ST_LOAD)        settle_cnt_q <= '0;
         else if (state_q == ST_SETTLE) settle_cnt_q <= settle_cnt_q + CNT_W'(1);
         if (start_scan) begin
            tap_q        <= '0;
            run_active_q <= 1'b0;
            best_valid_q <= 1'b0;
            scan_fail_q  <= 1'b0;
         end
         if (state_q == ST_EVAL && !scan_abort) begin
            if (!last_point) tap_q <= tap_next[TAP_W-1:0];
            if (tap_pass) begin
               run_active_q <= 1'b1;
               run_first_q  <= cand_first;
               run_last_q   <= tap_q;
            end else begin
               run_active_q <= 1'b0;
            end
            if (take_best) begin
               best_valid_q <= 1'b1;
               best_first_q <= close_first;
               best_last_q  <= close_last;
            end
         end
         if (state_q == ST_CENTER && !scan_abort) begin
            if (best_valid_q) begin
               scan_fail_q  <= 1'b0;
               eye_start_q  <= best_first_q;
               eye_width_q  <= best_width[TAP_W-1:0];
               eye_center_q <= TAP_W'({1'b0, best_first_q} + (best_width >> 1));
            end else begin
               scan_fail_q  <= 1'b1;
               eye_start_q  <= '0;
               eye_width_q  <= '0;
               eye_center_q <= '0;
            end
         end
      end
   end

`ifdef EYE_SCAN_LOG_EN
   logic [CNT_W-1:0] log_mem [LOG_DEPTH];
   logic [CNT_W-1:0] log_rd_q;
   logic [TAP_W-1:0] log_idx;

   assign log_idx = tap_q / TAP_W'(TAP_STEP);

   // Log contents are deliberately left unreset; only the read register clears.
   always_ff @(posedge clk160) begin
      if (state_q == ST_EVAL && log_idx < TAP_W'(LOG_DEPTH))
         log_mem[log_idx[LOG_AW-1:0]] <= err_acc;
   end

   always_ff @(posedge clk160 or negedge rstb) begin
      if (!rstb) log_rd_q <= '0;
      else       log_rd_q <= log_mem[log_addr];
   end

   assign log_data = log_rd_q;
`else
   logic log_addr_unused;
   assign log_addr_unused = ^log_addr;
   assign log_data        = '0;
`endif

endmodule

// File: tb/tb_idelay_eye_scanner.sv
// Directed bench for idelay_eye_scanner: three instances (step 8, step 4,
// single-point) share a behavioural IDELAY channel model selected by sel.
module tb_idelay_eye_scanner;

   logic        clk160 = 1'b0;
   logic        rstb   = 1'b0;
   logic [2:0]  scan_start = '0;
   logic        scan_abort = 1'b0;
   logic [15:0] dwell_cycles = 16'd4;
   logic [15:0] err_thresh   = 16'd0;
   logic [7:0]  data_p = '0;
   logic [7:0]  data_n = '1;
   logic        data_valid = 1'b1;
   logic [5:0]  log_addr = '0;

   logic [8:0]  delay_set [3];
   logic [8:0]  eye_start [3];
   logic [8:0]  eye_width [3];
   logic [8:0]  eye_center[3];
   logic        delay_wr  [3];
   logic        busy      [3];
   logic        done      [3];
   logic        scan_fail [3];
   logic [15:0] log_data  [3];

   int n_checks = 0;
   int n_pass   = 0;

   // channel model / monitor state
   int   sel = 0;
   int   cur_tap = 0;
   int   lo1 = 1000, hi1 = 0, lo2 = 1000, hi2 = 0;
   bit   toggle_mode = 1'b0;
   int   k = 0;
   int   wr_cnt = 0, done_cnt = 0, busy_cyc = 0;
   logic [8:0] last_wr = '0;
   logic busy_prev = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clk160 = ~clk160;

   // ---------------- DUTs ----------------
   idelay_eye_scanner #(.TAP_STEP(8), .TAP_MAX(511), .SETTLE_CYCLES(16)) u_a (
      .clk160(clk160), .rstb(rstb), .scan_start(scan_start[0]), .scan_abort(scan_abort),
      .dwell_cycles(dwell_cycles), .err_thresh(err_thresh), .data_p(data_p), .data_n(data_n),
      .data_valid(data_valid), .delay_set(delay_set[0]), .delay_wr(delay_wr[0]), .busy(busy[0]),
      .done(done[0]), .scan_fail(scan_fail[0]), .eye_start(eye_start[0]), .eye_width(eye_width[0]),
      .eye_center(eye_center[0]), .log_addr(log_addr), .log_data(log_data[0]));

   idelay_eye_scanner #(.TAP_STEP(4), .TAP_MAX(511), .SETTLE_CYCLES(16)) u_b (
      .clk160(clk160), .rstb(rstb), .scan_start(scan_start[1]), .scan_abort(scan_abort),
      .dwell_cycles(dwell_cycles), .err_thresh(err_thresh), .data_p(data_p), .data_n(data_n),
      .data_valid(data_valid), .delay_set(delay_set[1]), .delay_wr(delay_wr[1]), .busy(busy[1]),
      .done(done[1]), .scan_fail(scan_fail[1]), .eye_start(eye_start[1]), .eye_width(eye_width[1]),
      .eye_center(eye_center[1]), .log_addr(log_addr), .log_data(log_data[1]));

   idelay_eye_scanner #(.TAP_STEP(64), .TAP_MAX(63), .SETTLE_CYCLES(16)) u_c (
      .clk160(clk160), .rstb(rstb), .scan_start(scan_start[2]), .scan_abort(scan_abort),
      .dwell_cycles(dwell_cycles), .err_thresh(err_thresh), .data_p(data_p), .data_n(data_n),
      .data_valid(data_valid), .delay_set(delay_set[2]), .delay_wr(delay_wr[2]), .busy(busy[2]),
      .done(done[2]), .scan_fail(scan_fail[2]), .eye_start(eye_start[2]), .eye_width(eye_width[2]),
      .eye_center(eye_center[2]), .log_addr(log_addr), .log_data(log_data[2]));

   function automatic bit in_eye(input int t);
      return (t >= lo1 && t <= hi1) || (t >= lo2 && t <= hi2);
   endfunction

   // IDELAY model: latches the tap on delay_wr; outside the eye every bit is wrong.
   always @(negedge clk160) begin
      if (delay_wr[sel]) begin
         cur_tap = int'(delay_set[sel]);
         last_wr = delay_set[sel];
         wr_cnt++;
      end
      if (done[sel]) done_cnt++;
      if (busy[sel]) begin
         k = busy_prev ? k + 1 : 0;
         busy_cyc++;
      end
      busy_prev  = busy[sel];
      data_valid = toggle_mode ? (busy[sel] && (k % 2 == 0)) : 1'b1;
      data_p     = 8'($urandom_range(0, 255));
      data_n     = in_eye(cur_tap) ? ~data_p : data_p;
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic start_scan(input int which);
      @(negedge clk160);
      scan_start[which] = 1'b1;
      @(negedge clk160);
      scan_start = '0;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n;
      n = 0;
      while (busy[sel] && n < limit) begin
         @(negedge clk160);
         n++;
      end
      check({tag, "_timeout"}, 32'(n >= limit), 32'd0);
      repeat (2) @(negedge clk160);
   endtask

   task automatic clear_counts();
      wr_cnt   = 0;
      done_cnt = 0;
      busy_cyc = 0;
   endtask

   task automatic check_results(input string tag, input int es, input int ew, input int ec, input int sf);
      check({tag, "_eye_start"},  32'(eye_start[sel]),  32'(es));
      check({tag, "_eye_width"},  32'(eye_width[sel]),  32'(ew));
      check({tag, "_eye_center"}, 32'(eye_center[sel]), 32'(ec));
      check({tag, "_scan_fail"},  32'(scan_fail[sel]),  32'(sf));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_delay_set"}, 32'(delay_set[0]), 32'd0);
      check({tag, "_delay_wr"},  32'(delay_wr[0]),  32'd0);
      check({tag, "_busy"},      32'(busy[0]),      32'd0);
      check({tag, "_done"},      32'(done[0]),      32'd0);
      check_results(tag, 0, 0, 0, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int wr0;
      repeat (3) @(negedge clk160);
      check_all_zero("reset");
      check("reset_log_data", 32'(log_data[0]), 32'd0);
      rstb = 1'b1;
      repeat (2) @(negedge clk160);

      // every word fully wrong: no passing tap
      sel = 0; lo1 = 1000; hi1 = 0;
      clear_counts();
      start_scan(0);
      wait_idle("allbad", 5000);
      check_results("allbad", 0, 0, 0, 1);
      check("allbad_last_wr",   32'(last_wr),      32'd0);
      check("allbad_delay_set", 32'(delay_set[0]), 32'd0);
      check("allbad_done_cnt",  32'(done_cnt),     32'd1);
      check("allbad_wr_cnt",    32'(wr_cnt),       32'd65);

      // eye 64..192, plus a start pulse while busy that must be ignored
      lo1 = 64; hi1 = 192;
      clear_counts();
      start_scan(0);
      check("eye_fail_cleared", 32'(scan_fail[0]), 32'd0);
      check("eye_busy",         32'(busy[0]),      32'd1);
      repeat (100) @(negedge clk160);
      start_scan(0);
      wait_idle("eye", 5000);
      check_results("eye", 64, 128, 128, 0);
      check("eye_last_wr",   32'(last_wr),      32'd128);
      check("eye_delay_set", 32'(delay_set[0]), 32'd128);
      check("eye_done_cnt",  32'(done_cnt),     32'd1);
      check("eye_wr_cnt",    32'(wr_cnt),       32'd65);

      // abort during DWELL at tap 96
      clear_counts();
      start_scan(0);
      n = 0;
      while (!(delay_wr[0] && delay_set[0] == 9'd96) && n < 5000) begin
         @(negedge clk160);
         n++;
      end
      check("abort_find_tap96_timeout", 32'(n >= 5000), 32'd0);
      repeat (18) @(negedge clk160);
      wr0 = wr_cnt;
      scan_abort = 1'b1;
      @(negedge clk160);
      scan_abort = 1'b0;
      check("abort_busy", 32'(busy[0]), 32'd0);
      repeat (50) @(negedge clk160);
      check("abort_no_wr",   32'(wr_cnt),   32'(wr0));
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check_results("abort", 64, 128, 128, 0);

      // abort and start in the same idle cycle: abort wins
      @(negedge clk160);
      scan_abort = 1'b1;
      scan_start[0] = 1'b1;
      @(negedge clk160);
      scan_abort = 1'b0;
      scan_start = '0;
      check("abort_start_busy", 32'(busy[0]), 32'd0);
      repeat (5) @(negedge clk160);
      check("abort_start_no_wr", 32'(wr_cnt), 32'(wr0));

      // reset asserted during SETTLE, then a clean rescan
      start_scan(0);
      repeat (5) @(negedge clk160);
      wr0 = wr_cnt;
      rstb = 1'b0;
      #1;
      check_all_zero("rst_mid");
      repeat (3) @(negedge clk160);
      check_all_zero("rst_hold");
      check("rst_no_wr", 32'(wr_cnt), 32'(wr0));
      rstb = 1'b1;
      repeat (2) @(negedge clk160);
      clear_counts();
      start_scan(0);
      wait_idle("rescan", 5000);
      check_results("rescan", 64, 128, 128, 0);
      check("rescan_last_wr", 32'(last_wr), 32'd128);
`ifdef EYE_SCAN_LOG_EN
      log_addr = 6'd0;  repeat (2) @(negedge clk160);
      check("log_a_tap0",   32'(log_data[0]), 32'd32);
      log_addr = 6'd8;  repeat (2) @(negedge clk160);
      check("log_a_tap64",  32'(log_data[0]), 32'd0);
      log_addr = 6'd63; repeat (2) @(negedge clk160);
      check("log_a_tap504", 32'(log_data[0]), 32'd32);
`else
      log_addr = 6'd0;  repeat (2) @(negedge clk160);
      check("log_disabled", 32'(log_data[0]), 32'd0);
`endif

      // two equal 40-tap runs: the lower one wins
      sel = 1; lo1 = 16; hi1 = 56; lo2 = 300; hi2 = 340;
      busy_prev = 1'b0;
      clear_counts();
      start_scan(1);
      wait_idle("tie", 8000);
      check_results("tie", 16, 40, 36, 0);
      check("tie_last_wr",  32'(last_wr),  32'd36);
      check("tie_done_cnt", 32'(done_cnt), 32'd1);

      // saturation: 10000 words x 8 errors clamps at 0xFFFF (a wrap would pass)
      sel = 2; lo1 = 1000; hi1 = 0; lo2 = 1000; hi2 = 0;
      busy_prev = 1'b0;
      dwell_cycles = 16'd10000;
      err_thresh   = 16'hFFFE;
      clear_counts();
      start_scan(2);
      wait_idle("sat", 15000);
      check("sat_scan_fail", 32'(scan_fail[2]), 32'd1);
      check("sat_busy_cyc",  32'(busy_cyc),     32'd10020);
`ifdef EYE_SCAN_LOG_EN
      log_addr = 6'd0; repeat (2) @(negedge clk160);
      check("sat_log", 32'(log_data[2]), 32'hFFFF);
`endif

      // data_valid at 50%: dwell phase doubles in length
      err_thresh  = 16'hFFFF;
      toggle_mode = 1'b1;
      clear_counts();
      start_scan(2);
      wait_idle("half", 25000);
      toggle_mode = 1'b0;
      check("half_busy_cyc", 32'(busy_cyc), 32'd20020);
      check_results("half", 0, 0, 0, 0);
      check("half_done_cnt", 32'(done_cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
